// File: rtl/fb_line_prefetch_if.sv
// Line-request, RAM port-B and pixel-path bundle for fb_line_prefetch.
// pattern_sel is present only when FBLF_TEST_PATTERN_EN is defined.
interface fb_line_prefetch_if #(
   parameter int AW = 15,
   parameter int DW = 16
);
   logic          line_req;
   logic [9:0]    line_num;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata;
   logic          pix_en;
   logic [9:0]    pix_x;
   logic [7:0]    pix_out;
   logic          busy;
   logic          overrun;
`ifdef FBLF_TEST_PATTERN_EN
   logic          pattern_sel;

   modport master (
      output line_req, line_num, ram_rdata, pix_en, pix_x, pattern_sel,
      input  ram_addr, pix_out, busy, overrun
   );
   modport slave (
      input  line_req, line_num, ram_rdata, pix_en, pix_x, pattern_sel,
      output ram_addr, pix_out, busy, overrun
   );
`else
   modport master (
      output line_req, line_num, ram_rdata, pix_en, pix_x,
      input  ram_addr, pix_out, busy, overrun
   );
   modport slave (
      input  line_req, line_num, ram_rdata, pix_en, pix_x,
      output ram_addr, pix_out, busy, overrun
   );
`endif
endinterface

// File: rtl/fb_line_prefetch.sv
// Ping-pong scan-line prefetcher with power-of-two upscale; FBLF_TEST_PATTERN_EN adds a test pattern.
// Pixel latency 1 cycle; no backpressure: an early line_req aborts the fetch and sets sticky overrun.
module fb_line_prefetch #(
   parameter int H_PIX      = 160,
   parameter int V_ROWS     = 120,
   parameter int V_ACTIVE   = 480,
   parameter int SCALE_LOG2 = 2,
   parameter int BASE_ADDR  = 0,
   parameter int AW         = 15,
   parameter int DW         = 16
) (
   input logic               clk,
   input logic               reset,
   fb_line_prefetch_if.slave bus
);
   localparam int            IW       = $clog2(H_PIX);
   localparam logic [IW-1:0] LAST_COL = IW'(H_PIX - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state, state_nxt;
   logic          start, fill_done;
   logic [IW-1:0] col, p_idx;
   logic          p_vld;
   logic          sel;
   logic          front_valid, back_valid;
   logic          overrun_q;
   logic [AW-1:0] ram_addr_q;
   logic [7:0]    pix_q;
   logic [7:0]    buf0 [H_PIX];
   logic [7:0]    buf1 [H_PIX];
   logic [10:0]   next_line, row;
   logic [AW-1:0] start_addr;
   logic [9:0]    xs;
   logic          in_range;
   logic [7:0]    front_pix;
   logic          unused_rdata;

   assign unused_rdata = ^bus.ram_rdata[DW-1:8];
   assign bus.ram_addr = ram_addr_q;
   assign bus.pix_out  = pix_q;
   assign bus.overrun  = overrun_q;
   assign bus.busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      fill_done = 1'b0;
      case (state)
         IDLE: begin
            if (bus.line_req) begin
               start     = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (bus.line_req)           start     = 1'b1;
            else if (col == LAST_COL)   state_nxt = DRAIN;
         end
         DRAIN: begin
            if (bus.line_req) begin
               start     = 1'b1;
               state_nxt = FETCH;
            end else begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Row of the line after line_num, wrapped at the end of the frame and clamped to the source.
   always_comb begin
      next_line = {1'b0, bus.line_num} + 11'd1;
      if (next_line == 11'(V_ACTIVE)) next_line = '0;
      row = next_line >> SCALE_LOG2;
      if (row >= 11'(V_ROWS)) row = '0;
      start_addr = AW'(BASE_ADDR + int'(row) * H_PIX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr_q  <= '0;
         col         <= '0;
         p_vld       <= 1'b0;
         p_idx       <= '0;
         sel         <= 1'b0;
         front_valid <= 1'b0;
         back_valid  <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (start) begin
         sel         <= ~sel;
         front_valid <= back_valid;
         back_valid  <= 1'b0;
         ram_addr_q  <= start_addr;
         col         <= '0;
         p_vld       <= 1'b0;
         if (state != IDLE) overrun_q <= 1'b1;
      end else begin
         p_vld <= (state == FETCH);
         p_idx <= col;
         if (state == FETCH && col != LAST_COL) begin
            col        <= col + IW'(1);
            ram_addr_q <= ram_addr_q + AW'(1);
         end
         if (fill_done) back_valid <= 1'b1;
      end
   end

   // sel=0: buf0 is front, buf1 is back. Writes are dropped on the swap edge so an
   // aborted fetch cannot leave a late byte in either buffer.
   always_ff @(posedge clk) begin
      if (!reset && !start && p_vld) begin
         if (sel) buf0[p_idx] <= bus.ram_rdata[7:0];
         else     buf1[p_idx] <= bus.ram_rdata[7:0];
      end
   end

   always_comb begin
      xs        = bus.pix_x >> SCALE_LOG2;
      in_range  = (xs < 10'(H_PIX));
      front_pix = sel ? buf1[xs[IW-1:0]] : buf0[xs[IW-1:0]];
   end

`ifdef FBLF_TEST_PATTERN_EN
   logic [7:0] line_hi_q;

   always_ff @(posedge clk) begin
      if (reset)             line_hi_q <= '0;
      else if (bus.line_req) line_hi_q <= bus.line_num[9:2];
   end

   always_ff @(posedge clk) begin
      if (reset)
         pix_q <= '0;
      else if (bus.pattern_sel && bus.pix_en)
         pix_q <= bus.pix_x[9:2] ^ line_hi_q;
      else if (bus.pix_en && front_valid && in_range)
         pix_q <= front_pix;
      else
         pix_q <= '0;
   end
`else
   always_ff @(posedge clk) begin
      if (reset)
         pix_q <= '0;
      else if (bus.pix_en && front_valid && in_range)
         pix_q <= front_pix;
      else
         pix_q <= '0;
   end
`endif
endmodule
